vga_interface: RTL



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pixel_divider.sv | 26 ++
 rtl/vga_interface.sv | 101 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants, derived sync windows and fixed colours.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF = 4;
  localparam int H_VIS_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_VIS_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;

  localparam int H_TOT    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_VIS_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
  localparam int VS_START = V_VIS_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

  localparam logic [7:0] BORDER_COLOUR = 8'b00111000;
  localparam logic [7:0] BLANK_COLOUR  = 8'h00;

  // Inclusive window test on a 10-bit counter.
  function automatic logic in_span(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_divider.sv
// Pixel-rate divider: div counts 0..CLK_DIV-1; tick is high on the last system clock of each pixel.
module vga_pixel_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic tick
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/vga_interface.sv
// VGA timing generator and pin driver; COLOUR_OUT/HS/VS registered together one pixel after the address.
// Define VGA_BORDER_EN to paint a one-pixel border around the visible area.
module vga_interface
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COLOUR_IN,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  output logic [7:0] COLOUR_OUT,
  output logic       HS,
  output logic       VS,
  output logic       FRAME_START
);

  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_VIS + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_VIS + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic       tick;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       h_last;
  logic       v_last;
  logic       visible;
  logic       hs_on;
  logic       vs_on;
  logic [7:0] pix_colour;

  vga_pixel_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (tick)
  );

`ifdef VGA_BORDER_EN
  logic on_border;
  assign on_border = (hcnt == 10'd0) || (hcnt == 10'(H_VIS - 1)) ||
                     (vcnt == 10'd0) || (vcnt == 10'(V_VIS - 1));
`endif

  always_comb begin
    h_last     = (hcnt == 10'(H_TOTAL - 1));
    v_last     = (vcnt == 10'(V_TOTAL - 1));
    visible    = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
    hs_on      = in_span(hcnt, HS_FIRST, HS_LAST);
    vs_on      = in_span(vcnt, VS_FIRST, VS_LAST);
    pix_colour = BLANK_COLOUR;
    if (visible) begin
      pix_colour = COLOUR_IN;
`ifdef VGA_BORDER_EN
      if (on_border) begin
        pix_colour = BORDER_COLOUR;
      end
`endif
    end
  end

  // Addresses follow the counters, so they move on the CLK after tick and COLOUR_IN
  // has the remaining CLK_DIV-1 cycles of the pixel to settle before it is sampled.
  assign ADDRH = visible ? hcnt : 10'd0;
  assign ADDRV = visible ? vcnt[8:0] : 9'd0;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      COLOUR_OUT  <= BLANK_COLOUR;
      HS          <= 1'b1;
      VS          <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= tick && h_last && v_last;
      if (tick) begin
        hcnt <= h_last ? 10'd0 : hcnt + 10'd1;
        if (h_last) begin
          vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
        end
        // Output stage sees the pre-increment counters, keeping colour and syncs aligned.
        COLOUR_OUT <= pix_colour;
        HS         <= !hs_on;
        VS         <= !vs_on;
      end
    end
  end

endmodule
